// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PERF_W     = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_data_cnt
`endif
);

    arb_state_t        state, state_nxt;
    grant_t            last_grant, grant_nxt;
    logic              req_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              data_wins;

    // Data wins unless it was served last and a fetch is also waiting.
    assign data_wins = d_req && (!if_req || (last_grant == GRANT_FETCH));

    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        req_nxt   = mem_req;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        case (state)
            ARB_IDLE: begin
                if (data_wins) begin
                    state_nxt = ARB_DATA;
                    req_nxt   = 1'b1;
                    we_nxt    = d_we;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                end else if (if_req) begin
                    state_nxt = ARB_FETCH;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = if_addr;
                    wdata_nxt = '0;
                end
            end
            ARB_FETCH: begin
                if (mem_ack) begin
                    state_nxt = ARB_IDLE;
                    req_nxt   = 1'b0;
                    grant_nxt = GRANT_FETCH;
                end
            end
            ARB_DATA: begin
                if (mem_ack) begin
                    state_nxt = ARB_IDLE;
                    req_nxt   = 1'b0;
                    grant_nxt = GRANT_DATA;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_DATA;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            mem_req    <= req_nxt;
            mem_we     <= we_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
        end
    end

    // A withdrawn requester still lets the memory finish, but sees no ready.
    assign if_ready = (state == ARB_FETCH) && mem_ack && if_req;
    assign d_ready  = (state == ARB_DATA) && mem_ack && d_req;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign stall    = (if_req && !if_ready) || (d_req && !d_ready);

`ifdef ARB_PERF_CNT_EN
    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall),
        .count   (perf_stall_cyc)
    );

    sat_counter #(.WIDTH(PERF_W)) u_fetch_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     ((state == ARB_FETCH) && mem_ack),
        .count   (perf_fetch_cnt)
    );

    sat_counter #(.WIDTH(PERF_W)) u_data_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     ((state == ARB_DATA) && mem_ack),
        .count   (perf_data_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, stall;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_stall_cyc, perf_fetch_cnt, perf_data_cnt;
    logic        sat_inc = 1'b0;
    logic [1:0]  sat_cnt;
    int          stall_seen = 0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_data_cnt  (perf_data_cnt)
`endif
    );

`ifdef ARB_PERF_CNT_EN
    sat_counter #(.WIDTH(2)) u_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (sat_inc),
        .count   (sat_cnt)
    );

    always @(negedge clk) if (reset_n && stall) stall_seen++;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          chk_data;
        int          at;
        int          id;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic expect_ready(input bit is_data, input logic [31:0] rd, input bit chk, input int at, input int id);
        exp_t e;
        e.is_data  = is_data;
        e.rdata    = rd;
        e.chk_data = chk;
        e.at       = at;
        e.id       = id;
        sb.push_back(e);
    endtask

    // Memory model: acks k cycles after mem_req first appears.
    logic [31:0] mem [logic [31:0]];
    int k    = 0;
    bit busy = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (!busy) begin
                busy = 1;
                wcnt = k;
            end
            if (wcnt == 0) begin
                mem_ack = 1'b1;
                busy    = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    mem_rdata     = 32'h0;
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt--;
            end
        end else begin
            mem_ack = 1'b0;
            busy    = 0;
        end
    end

    task automatic pop_check(input bit is_data, input logic [31:0] rd);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got %s ready at cycle %0d, want no ready",
                     is_data ? "data" : "fetch", cyc);
            return;
        end
        e = sb.pop_front();
        check($sformatf("txn%0d_kind", e.id), 64'(is_data), 64'(e.is_data));
        check($sformatf("txn%0d_cycle", e.id), 64'(cyc), 64'(e.at));
        if (e.chk_data) check($sformatf("txn%0d_rdata", e.id), 64'(rd), 64'(e.rdata));
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (if_ready && d_ready) begin
                total++;
                bad++;
                $display("FAIL both_ready: got both ready at cycle %0d, want at most one", cyc);
            end
            if (if_ready) pop_check(1'b0, if_rdata);
            if (d_ready) pop_check(1'b1, d_rdata);
        end
    end

    task automatic wait_ready(input bit is_data, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(is_data ? d_ready : if_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready in 50 cycles, want ready", name);
        end
    endtask

    task automatic fetcher(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if_req  = 1'b1;
            if_addr = base + 32'(4 * i);
            wait_ready(1'b0, "fetcher");
            @(posedge clk);
            #1;
        end
        if_req = 1'b0;
    endtask

    task automatic loader(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = base + 32'(4 * i);
            wait_ready(1'b1, "loader");
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        mem[32'h40]  = 32'h2008_0005;
        mem[32'h200] = 32'h1111_0000;
        mem[32'h204] = 32'h1111_0004;
        mem[32'h208] = 32'h1111_0008;
        mem[32'h300] = 32'hAAAA_0000;
        mem[32'h304] = 32'hAAAA_0004;
        reset_n = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;

`ifdef ARB_PERF_CNT_EN
        @(posedge clk);
        #1 sat_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 sat_inc = 1'b0;
        @(negedge clk);
        check("sat_below_max", 64'(sat_cnt), 64'd2);
        #1 sat_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1 sat_inc = 1'b0;
        @(negedge clk);
        check("sat_hold_max", 64'(sat_cnt), 64'd3);
`endif

        // Contention after reset: last grant is DATA, so FETCH goes first.
        @(posedge clk);
        #1;
        k  = 2;
        t0 = cyc;
        expect_ready(1'b0, 32'h1111_0000, 1'b1, t0 + 3,  1);
        expect_ready(1'b1, 32'hAAAA_0000, 1'b1, t0 + 7,  2);
        expect_ready(1'b0, 32'h1111_0004, 1'b1, t0 + 11, 3);
        expect_ready(1'b1, 32'hAAAA_0004, 1'b1, t0 + 15, 4);
        expect_ready(1'b0, 32'h1111_0008, 1'b1, t0 + 19, 5);
        fork
            fetcher(3, 32'h200);
            loader(2, 32'h300);
        join
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'd3);
        check("perf_data_cnt", 64'(perf_data_cnt), 64'd2);
        check("perf_stall_cyc", 64'(perf_stall_cyc), 64'(stall_seen));
`endif

        // Lone fetch with zero wait cycles.
        @(posedge clk);
        #1;
        k       = 0;
        t0      = cyc;
        if_req  = 1'b1;
        if_addr = 32'h40;
        expect_ready(1'b0, 32'h2008_0005, 1'b1, t0 + 1, 6);
        @(negedge clk);
        check("fetch_stall_c0", 64'(stall), 64'd1);
        check("fetch_memreq_c0", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("fetch_memreq_c1", 64'(mem_req), 64'd1);
        check("fetch_addr_c1", 64'(mem_addr), 64'h40);
        check("fetch_we_c1", 64'(mem_we), 64'd0);
        check("fetch_stall_c1", 64'(stall), 64'd0);
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        check("fetch_stall_c2", 64'(stall), 64'd0);
        check("fetch_memreq_c2", 64'(mem_req), 64'd0);

        // Store with three wait cycles; address change in flight is ignored.
        @(posedge clk);
        #1;
        k       = 3;
        t0      = cyc;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        expect_ready(1'b1, 32'h0, 1'b0, t0 + 4, 7);
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("store_req_c%0d", i), 64'(mem_req), 64'd1);
            check($sformatf("store_we_c%0d", i), 64'(mem_we), 64'd1);
            check($sformatf("store_addr_c%0d", i), 64'(mem_addr), 64'h100);
            check($sformatf("store_wdata_c%0d", i), 64'(mem_wdata), 64'hDEAD_BEEF);
            if (i == 1) d_addr = 32'h180;
        end
        @(posedge clk);
        #1 d_req = 1'b0;
        d_we = 1'b0;
        @(negedge clk);
        check("store_req_done", 64'(mem_req), 64'd0);
        check("store_mem_word", 64'(mem.exists(32'h100) ? mem[32'h100] : 32'h0), 64'hDEAD_BEEF);
        check("store_no_stray", 64'(mem.exists(32'h180)), 64'd0);

        // Fetch withdrawn by a flush after one cycle.
        @(posedge clk);
        #1;
        k       = 3;
        if_req  = 1'b1;
        if_addr = 32'h44;
        @(posedge clk);
        #1 if_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("flush_req_c%0d", i), 64'(mem_req), 64'd1);
            check($sformatf("flush_ready_c%0d", i), 64'(if_ready), 64'd0);
        end
        @(negedge clk);
        check("flush_req_done", 64'(mem_req), 64'd0);
        check("flush_stall_done", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        k  = 1;
        t0 = cyc;
        expect_ready(1'b1, 32'hAAAA_0000, 1'b1, t0 + 2, 8);
        loader(1, 32'h300);

        // Asynchronous reset while a load is waiting on memory.
        @(posedge clk);
        #1;
        k      = 3;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h304;
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_mem_req", 64'(mem_req), 64'd0);
        check("arst_mem_addr", 64'(mem_addr), 64'd0);
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        k  = 0;
        t0 = cyc;
        expect_ready(1'b0, 32'h2008_0005, 1'b1, t0 + 1, 9);
        expect_ready(1'b1, 32'hAAAA_0000, 1'b1, t0 + 3, 10);
        fork
            fetcher(1, 32'h40);
            loader(1, 32'h300);
        join
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw data access) of the five-stage pipeline.
- Sequences each memory transaction with a req/ack handshake that tolerates variable memory latency.
- Drives a global stall to the hazard logic until the pending requests of both stages are served.
- Data accesses normally win; a starvation guard alternates grants under contention.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width

Ports:
clk  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
if_req  input  1  IF stage requests fetch; held until if_ready
if_addr  input  ADDR_W  fetch address (PC)
if_rdata  output  DATA_W  fetched instruction, valid when if_ready
if_ready  output  1  fetch complete this cycle
d_req  input  1  MEM stage access (memwrite | memtoreg); held until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address (ALU result)
d_wdata  input  DATA_W  store data
d_rdata  output  DATA_W  load data, valid when d_ready
d_ready  output  1  data access complete this cycle
mem_req  output  1  registered request to memory
mem_we  output  1  registered write enable
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  memory completes current transaction
stall  output  1  freeze pipeline

Behaviour:
- Reset (reset_n low, asynchronous): state ARB_IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; last_grant = DATA. Any in-flight transaction is abandoned and the memory must tolerate this.
- States: ARB_IDLE, ARB_FETCH, ARB_DATA.
- ARB_IDLE arbitration:
  - d_req only: go to ARB_DATA.
  - if_req only: go to ARB_FETCH.
  - Both: go to ARB_FETCH if last_grant==DATA, else ARB_DATA.
  - Neither: stay in ARB_IDLE.
- Grant: on the transition out of ARB_IDLE, latch the winner's address, we and wdata into mem_* and set mem_req=1. Fetch forces mem_we=0.
- ARB_FETCH / ARB_DATA: mem_req held high and mem_* stable until mem_ack.
  - On mem_ack: clear mem_req, update last_grant, return to ARB_IDLE.
  - No back-to-back grant: ARB_IDLE always lasts at least one cycle between transactions.
- Ready outputs (combinational, same cycle as mem_ack):
  - if_ready = (state==ARB_FETCH) & mem_ack & if_req; if_rdata = mem_rdata.
  - d_ready = (state==ARB_DATA) & mem_ack & d_req; d_rdata = mem_rdata.
  - Rdata outputs are don't-care when ready is low; the bench checks them only with ready.
- Latency: a request first seen in ARB_IDLE at cycle N gives mem_req at N+1 and ready at N+1+k, where k = memory wait cycles (k≥0).
- stall = (if_req & ~if_ready) | (d_req & ~d_ready). Combinational; low when there are no requests.
- Requester withdraws mid-transaction (if_req dropped by branch flush, or d_req dropped): the transaction still completes at memory. Ready stays suppressed, and a store is still performed. Not an error.
- Request address changes while a transaction is in flight are ignored; the latched address is used.
- mem_ack while in ARB_IDLE is ignored.
- Stores: memory completion is mem_ack; d_rdata is don't-care for stores.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cyc, perf_fetch_cnt and perf_data_cnt (32 bits each).
  - perf_stall_cyc increments on every cycle with stall=1.
  - perf_fetch_cnt and perf_data_cnt increment on each completed transaction of their type, counting the mem_ack, including withdrawn transactions.
  - All counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: no perf ports, no counter logic.

Decomposition:
- Package mips_mem_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_FETCH, ARB_DATA};
  - enum grant_t {GRANT_FETCH, GRANT_DATA};
  - ADDR_W and DATA_W default constants;
  - PERF_W = 32.
- Sub-module sat_counter (width param, inc, clk, reset_n, count) is instantiated three times under ARB_PERF_CNT_EN.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x0000_0040, memory k=0 returns 0x2008_0005 → mem_req at cycle 1 with addr 0x40 and we=0; if_ready and if_rdata=0x2008_0005 at cycle 1; stall high at cycle 0 only.
- Contention alternation: if_req and d_req held high, k=2, completing ready on ack → grant order FETCH, DATA, FETCH, DATA. Each transaction takes 4 cycles including ARB_IDLE; the ready pulse lasts one cycle per ack.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, k=3 → mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF held stable for 4 cycles; d_ready on ack; memory word 0x100 = 0xDEAD_BEEF.
- Flush withdrawal: fetch in flight with k=3, if_req drops after 1 cycle → mem_req stays high until ack; if_ready never asserts; FSM returns to ARB_IDLE; next d_req is granted normally.
- Async reset mid-transaction: reset_n low between clock edges while in ARB_DATA → mem_req=0 immediately; after release the FSM is in ARB_IDLE and the first contended grant is FETCH.
- With ARB_PERF_CNT_EN: run the contention scenario for 3 fetches and 2 data accesses → perf_fetch_cnt=3, perf_data_cnt=2, perf_stall_cyc equals the bench-counted stall cycles. Separately, force a counter to 0xFFFF_FFFE, apply 3 increments → stays at 0xFFFF_FFFF.
